stripe_animator: RTL and testbench

- Parametrised successor to the static bottom-stripe drawer in the VGA display path.
- Sits between the VGA timing controller (hcount/vcount/blank) and the colour mux feeding the DAC pins.
- Draws a full-width horizontal stripe whose row position and visibility are frame-animated: static, wrapping scroll, bounce or blink.
- Output is registered, and position updates only at the start of vertical blank, so there is no tearing.

---
 rtl/stripe_animator.sv | 159 +++++++++++++++
 tb/tb_stripe_animator.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stripe_animator.sv
// Frame-animated full-width horizontal stripe overlay for the VGA colour path.
// The position and blink state change only on the frame event, which falls in vertical blank.
// The pixel output is registered and lags the timing inputs by one clock.
module stripe_animator #(
   parameter int unsigned CW        = 11,
   parameter int unsigned COLOR_W   = 12,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned STRIPE_H  = 32,
   parameter int unsigned INIT_Y    = 448,
   parameter int unsigned STEP      = 4,
   parameter int unsigned FRAME_DIV = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               en,
   input  logic [1:0]         mode,
   input  logic [COLOR_W-1:0] color_in,
   input  logic [CW-1:0]      hcount,
   input  logic [CW-1:0]      vcount,
   input  logic               blank,
   output logic [COLOR_W-1:0] color_out,
   output logic               frame_tick,
   output logic [CW-1:0]      stripe_y
);

   localparam int unsigned CW1 = CW + 1;
   localparam int unsigned DW  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   // Row arithmetic is done one bit wider so sums near the bottom cannot overflow.
   localparam logic [CW:0]   VA       = CW1'(V_ACTIVE);
   localparam logic [CW:0]   STEP_W   = CW1'(STEP);
   localparam logic [CW:0]   Y_MAX    = CW1'(V_ACTIVE - STRIPE_H);
   localparam logic [CW:0]   H_M1     = CW1'(STRIPE_H - 1);
   localparam logic [CW-1:0] Y_INIT   = CW'(INIT_Y);
   localparam logic [CW-1:0] STEP_N   = CW'(STEP);
   localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);

   localparam logic [1:0] M_STATIC = 2'b00;
   localparam logic [1:0] M_SCROLL = 2'b01;
   localparam logic [1:0] M_BOUNCE = 2'b10;
   localparam logic [1:0] M_BLINK  = 2'b11;

   // Bounce direction states
   localparam logic [0:0] DOWN = 1'b0;
   localparam logic [0:0] UP   = 1'b1;

   logic          cond, cond_q, evt;
   logic [1:0]    mode_q, mode_d;
   logic [0:0]    dir_q, dir_d;
   logic          vis_q, vis_d;
   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] y_d;
   logic [CW:0]   sum, bot;
   logic          hit;

   // Frame event: rising edge of the "first pixel of vblank" condition
   always_comb begin
      cond = (hcount == '0) && ({1'b0, vcount} == VA);
      evt  = cond && !cond_q;
   end

   // Animation next-state: mode latch, divider, and per-mode step action
   always_comb begin
      y_d    = stripe_y;
      dir_d  = dir_q;
      div_d  = div_q;
      vis_d  = vis_q;
      mode_d = mode_q;
      sum    = {1'b0, stripe_y} + STEP_W;
      if (evt) begin
         mode_d = mode;
         if (mode != mode_q) begin
            // A mode change restarts the animation and suppresses that frame's step
            div_d = '0;
            dir_d = DOWN;
            if (mode == M_STATIC || mode == M_BLINK) begin
               y_d   = Y_INIT;
               vis_d = 1'b1;
            end
         end else if (en) begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               case (mode_q)
                  M_SCROLL: begin
                     if (sum >= VA) y_d = CW'(sum - VA);
                     else           y_d = CW'(sum);
                  end
                  M_BOUNCE: begin
                     if (dir_q == DOWN) begin
                        if (sum >= Y_MAX) begin
                           y_d   = CW'(Y_MAX);
                           dir_d = UP;
                        end else begin
                           y_d = CW'(sum);
                        end
                     end else begin
                        if ({1'b0, stripe_y} <= STEP_W) begin
                           y_d   = '0;
                           dir_d = DOWN;
                        end else begin
                           y_d = stripe_y - STEP_N;
                        end
                     end
                  end
                  M_BLINK: vis_d = ~vis_q;
                  default: ;
               endcase
            end else begin
               div_d = div_q + 1'b1;
            end
         end
      end
   end

   // Stripe hit test; only scroll mode can place the stripe across the bottom edge
   always_comb begin
      bot = {1'b0, stripe_y} + H_M1;
      if (bot < VA) begin
         hit = (vcount >= stripe_y) && ({1'b0, vcount} <= bot);
      end else begin
         hit = (vcount >= stripe_y) || ({1'b0, vcount} <= (bot - VA));
      end
   end

   // Animation state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cond_q     <= 1'b0;
         frame_tick <= 1'b0;
         stripe_y   <= Y_INIT;
         dir_q      <= DOWN;
         div_q      <= '0;
         vis_q      <= 1'b1;
         mode_q     <= M_STATIC;
      end else begin
         cond_q     <= cond;
         frame_tick <= evt;
         stripe_y   <= y_d;
         dir_q      <= dir_d;
         div_q      <= div_d;
         vis_q      <= vis_d;
         mode_q     <= mode_d;
      end
   end

   // Registered pixel output
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         color_out <= '0;
      end else if (blank) begin
         color_out <= '0;
      end else if (hit && (mode_q != M_BLINK || vis_q)) begin
         color_out <= color_in;
      end else begin
         color_out <= '0;
      end
   end

endmodule

// File: tb/tb_stripe_animator.sv
// Bench for stripe_animator: three instances (FRAME_DIV 1, 3, 2) share one stimulus stream.
// Expected pixel/tick values are queued when driven and compared one clock later.
module tb_stripe_animator;

   localparam int VA = 480;
   localparam int SH = 32;

   logic        clk      = 1'b0;
   logic        reset_n  = 1'b0;
   logic        en       = 1'b1;
   logic [1:0]  mode     = 2'b00;
   logic [11:0] color_in = 12'h00F;
   logic [10:0] hcount   = '0;
   logic [10:0] vcount   = 11'd500;
   logic        blank    = 1'b1;

   logic [11:0] col_a, col_b, col_c;
   logic        tick_a, tick_b, tick_c;
   logic [10:0] y_a, y_b, y_c;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [11:0] col;
      logic        tick;
      int          sel;
   } sb_t;

   sb_t sb[$];

   stripe_animator #(.FRAME_DIV(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .color_in(color_in),
      .hcount(hcount), .vcount(vcount), .blank(blank),
      .color_out(col_a), .frame_tick(tick_a), .stripe_y(y_a)
   );

   stripe_animator #(.FRAME_DIV(3)) dut_b (
      .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .color_in(color_in),
      .hcount(hcount), .vcount(vcount), .blank(blank),
      .color_out(col_b), .frame_tick(tick_b), .stripe_y(y_b)
   );

   stripe_animator #(.FRAME_DIV(2)) dut_c (
      .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .color_in(color_in),
      .hcount(hcount), .vcount(vcount), .blank(blank),
      .color_out(col_c), .frame_tick(tick_c), .stripe_y(y_c)
   );

   always #5 clk = ~clk;

   // Reference colour: the stripe covers STRIPE_H rows starting at y, modulo the visible height
   function automatic logic [11:0] expc(input int v, input bit b, input int y, input bit visb,
                                        input logic [11:0] c);
      if (b || !visb) return 12'h000;
      if (((v - y + VA) % VA) < SH) return c;
      return 12'h000;
   endfunction

   // Scoreboard consumer: each entry pushed at a negedge is due after the next posedge
   always @(posedge clk) begin
      sb_t         e;
      logic [11:0] ac;
      logic        at;
      #2;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.sel)
            1:       begin ac = col_b; at = tick_b; end
            2:       begin ac = col_c; at = tick_c; end
            default: begin ac = col_a; at = tick_a; end
         endcase
         checks++;
         if (ac !== e.col) begin
            errors++;
            $display("FAIL pix_color dut%0d v=%0d: got %h expected %h", e.sel, vcount, ac, e.col);
         end
         checks++;
         if (at !== e.tick) begin
            errors++;
            $display("FAIL frame_tick dut%0d: got %b expected %b", e.sel, at, e.tick);
         end
      end
   end

   task automatic pix(input int h, input int v, input bit b, input int sel,
                      input logic [11:0] ec, input bit et);
      sb_t e;
      @(negedge clk);
      hcount = 11'(h);
      vcount = 11'(v);
      blank  = b;
      e.col  = ec;
      e.tick = et;
      e.sel  = sel;
      sb.push_back(e);
   endtask

   task automatic frame();
      pix(0, VA, 1'b1, 0, 12'h000, 1'b1);
      pix(7, VA + 1, 1'b1, 0, 12'h000, 1'b0);
   endtask

   task automatic drain();
      @(posedge clk);
      #3;
   endtask

   task automatic do_reset();
      drain();
      reset_n = 1'b0;
      mode    = 2'b00;
      en      = 1'b1;
      hcount  = '0;
      vcount  = 11'd500;
      blank   = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      color_in = 12'h00F;
      mode = 2'b01;
      frame();
      frame();
      checks++;
      if (y_a !== 11'd452) begin
         errors++;
         $display("FAIL reset_pre_y: got %0d expected 452", y_a);
      end
      pix(10, 460, 1'b0, 0, expc(460, 1'b0, 452, 1'b1, color_in), 1'b0);
      drain();
      #1;
      reset_n = 1'b0;
      mode    = 2'b00;
      #1;
      checks++;
      if (col_a !== 12'h000) begin
         errors++;
         $display("FAIL reset_color: got %h expected 000", col_a);
      end
      checks++;
      if (y_a !== 11'd448) begin
         errors++;
         $display("FAIL reset_y: got %0d expected 448", y_a);
      end
      checks++;
      if (tick_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_tick: got %b expected 0", tick_a);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_static();
      int rows[8]  = '{0, 100, 447, 448, 460, 479, 460, 500};
      bit blnk[8]  = '{0, 0, 0, 0, 0, 0, 1, 1};
      for (int i = 0; i < 8; i++) begin
         pix(33 * i, rows[i], blnk[i], 0, expc(rows[i], blnk[i], 448, 1'b1, color_in), 1'b0);
      end
      drain();
   endtask

   task automatic test_scroll();
      int ey;
      int rows[6] = '{475, 476, 479, 0, 27, 28};
      do_reset();
      color_in = 12'hF80;
      mode = 2'b01;
      frame();
      checks++;
      if (y_a !== 11'd448) begin
         errors++;
         $display("FAIL scroll_latch_y: got %0d expected 448", y_a);
      end
      for (int k = 1; k <= 8; k++) begin
         frame();
         ey = (448 + 4 * k) % VA;
         checks++;
         if (y_a !== 11'(ey)) begin
            errors++;
            $display("FAIL scroll_y step %0d: got %0d expected %0d", k, y_a, ey);
         end
         if (k == 7) begin
            for (int i = 0; i < 6; i++) begin
               pix(20, rows[i], 1'b0, 0, expc(rows[i], 1'b0, 476, 1'b1, color_in), 1'b0);
            end
         end
      end
      drain();
   endtask

   task automatic test_bounce();
      int ey;
      int rows[4] = '{199, 200, 231, 232};
      do_reset();
      color_in = 12'h0F0;
      mode = 2'b10;
      frame();
      checks++;
      if (y_a !== 11'd448) begin
         errors++;
         $display("FAIL bounce_latch_y: got %0d expected 448", y_a);
      end
      for (int n = 1; n <= 114; n++) begin
         frame();
         if (n == 1)        ey = 448;
         else if (n <= 112) ey = 448 - 4 * (n - 1);
         else if (n == 113) ey = 0;
         else               ey = 4;
         checks++;
         if (y_a !== 11'(ey)) begin
            errors++;
            $display("FAIL bounce_y step %0d: got %0d expected %0d", n, y_a, ey);
         end
         if (n == 63) begin
            for (int i = 0; i < 4; i++) begin
               pix(50, rows[i], 1'b0, 0, expc(rows[i], 1'b0, 200, 1'b1, color_in), 1'b0);
            end
         end
      end
      drain();
   endtask

   task automatic test_divider_enable();
      int ey;
      do_reset();
      color_in = 12'hABC;
      mode = 2'b01;
      frame();
      for (int k = 1; k <= 9; k++) begin
         frame();
         ey = 448 + 4 * (k / 3);
         checks++;
         if (y_b !== 11'(ey)) begin
            errors++;
            $display("FAIL div3_y frame %0d: got %0d expected %0d", k, y_b, ey);
         end
      end
      en = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         frame();
         checks++;
         if (y_b !== 11'd460) begin
            errors++;
            $display("FAIL en_hold_y frame %0d: got %0d expected 460", k, y_b);
         end
      end
      pix(1, 460, 1'b0, 1, expc(460, 1'b0, 460, 1'b1, color_in), 1'b0);
      pix(2, 459, 1'b0, 1, expc(459, 1'b0, 460, 1'b1, color_in), 1'b0);
      pix(3, 5, 1'b0, 1, expc(5, 1'b0, 460, 1'b1, color_in), 1'b0);
      en = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         frame();
         ey = (k == 3) ? 464 : 460;
         checks++;
         if (y_b !== 11'(ey)) begin
            errors++;
            $display("FAIL div3_resume_y frame %0d: got %0d expected %0d", k, y_b, ey);
         end
      end
      drain();
   endtask

   task automatic test_blink();
      bit vis;
      do_reset();
      color_in = 12'h555;
      mode = 2'b11;
      frame();
      for (int k = 1; k <= 6; k++) begin
         frame();
         vis = ((k / 2) % 2) == 0;
         pix(9, 460, 1'b0, 2, expc(460, 1'b0, 448, vis, color_in), 1'b0);
         vis = (k % 2) == 0;
         pix(9, 470, 1'b0, 0, expc(470, 1'b0, 448, vis, color_in), 1'b0);
      end
      // Switch to static while the stripe is hidden
      mode = 2'b00;
      frame();
      checks++;
      if (y_c !== 11'd448) begin
         errors++;
         $display("FAIL blink_to_static_y: got %0d expected 448", y_c);
      end
      pix(9, 460, 1'b0, 2, expc(460, 1'b0, 448, 1'b1, color_in), 1'b0);
      // Scroll away, then a mode change that coincides with a divider rollover
      mode = 2'b01;
      frame();
      frame();
      frame();
      checks++;
      if (y_a !== 11'd456) begin
         errors++;
         $display("FAIL modechg_scroll_y: got %0d expected 456", y_a);
      end
      mode = 2'b11;
      frame();
      checks++;
      if (y_a !== 11'd448) begin
         errors++;
         $display("FAIL modechg_blink_y: got %0d expected 448", y_a);
      end
      pix(9, 450, 1'b0, 0, expc(450, 1'b0, 448, 1'b1, color_in), 1'b0);
      frame();
      pix(9, 450, 1'b0, 0, expc(450, 1'b0, 448, 1'b0, color_in), 1'b0);
      drain();
   endtask

   task automatic test_frame_tick();
      do_reset();
      pix(0, VA, 1'b1, 0, 12'h000, 1'b1);
      pix(0, VA, 1'b1, 0, 12'h000, 1'b0);
      pix(0, VA, 1'b1, 0, 12'h000, 1'b0);
      pix(3, VA + 1, 1'b1, 0, 12'h000, 1'b0);
      pix(0, VA, 1'b1, 0, 12'h000, 1'b1);
      pix(9, 10, 1'b1, 0, 12'h000, 1'b0);
      drain();
   endtask

   initial begin
      test_reset();
      test_static();
      test_scroll();
      test_bounce();
      test_divider_enable();
      test_blink();
      test_frame_tick();
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
